// File: rtl/alu_request_scheduler_pkg.sv
// alu_request_scheduler_pkg
//   Shared definitions for the ALU request scheduler: ALU opcode constants,
//   scheduler FSM state encoding, the captured-result record and the
//   illegal-opcode classifier used when ALU_ILLEGAL_OP_CHECK_EN is defined.
package alu_request_scheduler_pkg;

  // ALU opcodes understood by arithmetic_logic_unit.
  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OP_NOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1010;
  localparam logic [3:0] ALU_OP_SADD = 4'b1011;
  localparam logic [3:0] ALU_OP_SSUB = 4'b1100;
  localparam logic [3:0] ALU_OP_NOP  = 4'b1111;

  // Scheduler sequencing: grant, operand setup, opcode execute, response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Result record captured from the ALU at the end of EXEC.
  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        zero;
  } alu_capture_t;

  // Codes with no ALU operation behind them (NOP included: it is the idle code).
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b1101) || (op == 4'b1110) || (op == ALU_OP_NOP);
  endfunction

endpackage

// File: rtl/alu_request_scheduler_if.sv
// alu_request_scheduler_if
//   Requester, ALU and response signals of the ALU request scheduler.
//   slave  : the scheduler's view.
//   master : the surrounding system (requesters, ALU, response consumer).
interface alu_request_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);

  // Requester side: one valid/ready pair and one operation per requester.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_control;
  logic [32*NUM_REQ-1:0] req_op_a;
  logic [32*NUM_REQ-1:0] req_op_b;

  // ALU side.
  logic [3:0]            alu_control;
  logic [31:0]           alu_first_op;
  logic [31:0]           alu_second_op;
  logic [31:0]           alu_result;
  logic                  alu_overflow;
  logic                  alu_zero;

  // Response channel.
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_zero;
  logic                  rsp_error;

  logic                  busy;

  modport slave (
    input  req_valid, req_control, req_op_a, req_op_b,
    input  alu_result, alu_overflow, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_control, alu_first_op, alu_second_op,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_error,
    output busy
  );

  modport master (
    output req_valid, req_control, req_op_a, req_op_b,
    output alu_result, alu_overflow, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_control, alu_first_op, alu_second_op,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_error,
    input  busy
  );

endinterface

// File: rtl/alu_request_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: the first set request bit found
//   searching upward from ptr_i+1 (wrapping modulo NUM_REQ). Produces the
//   one-hot grant, its index and a flag saying whether anything was granted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  logic [IDW-1:0] cand;

  // Scan candidates in priority order ptr+1, ptr+2, ... ptr; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves a
    // variable unassigned, which is what keeps this block free of latches.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// alu_request_scheduler
//   Shares one ALU among NUM_REQ requesters. A round-robin grant in IDLE
//   latches the winner's opcode and operands; SETUP presents the operands with
//   the ALU parked on NOP, EXEC presents the opcode and captures the result,
//   RESP holds the response until the consumer takes it. Accept in cycle T
//   gives rsp_valid in T+3; peak rate is one operation every 4 cycles.
//   Optional build macro: ALU_ILLEGAL_OP_CHECK_EN -- opcodes 0101/1101/1110/1111
//   go straight from IDLE to RESP with rsp_error set and a zero result,
//   without touching the ALU. Without it every opcode is sequenced and
//   rsp_error is tied low.
module alu_request_scheduler
  import alu_request_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  alu_request_scheduler_if.slave        bus
);

  sched_state_e       state_q, state_d;

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [3:0]         ctrl_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  alu_capture_t       rsp_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_valid;

  logic [NUM_REQ-1:0] grant_now;
  logic               accept;
  logic               capture;
  logic               illegal_sel;

  logic [3:0]         req_ctrl [NUM_REQ];
  logic [31:0]        req_a    [NUM_REQ];
  logic [31:0]        req_b    [NUM_REQ];
  logic [3:0]         sel_ctrl;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  // Split the flat requester buses into per-requester slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_ctrl[gi] = bus.req_control[4*gi +: 4];
    assign req_a[gi]    = bus.req_op_a[32*gi +: 32];
    assign req_b[gi]    = bus.req_op_b[32*gi +: 32];
  end

  assign sel_ctrl = req_ctrl[arb_idx];
  assign sel_a    = req_a[arb_idx];
  assign sel_b    = req_b[arb_idx];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic rsp_error_q;

  assign illegal_sel = is_illegal_op(sel_ctrl);

  // Error flag belongs to the accepted operation; cleared by the next legal one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_error_q <= 1'b0;
    end else if (accept) begin
      rsp_error_q <= illegal_sel;
    end
  end

  assign bus.rsp_error = rsp_error_q;
`else
  assign illegal_sel   = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the accept/capture strobes for the datapath.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later lines see the
    // values assigned above them; clocked blocks use '<=' exclusively.
    state_d   = state_q;
    grant_now = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_now = arb_grant;
          accept    = 1'b1;
          state_d   = illegal_sel ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_EXEC;
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operation latch, round-robin pointer and response capture.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, because their reset
    // values are visible on the ALU operand and rsp_* outputs.
    if (!reset_n) begin
      ptr_q  <= IDW'(NUM_REQ - 1);
      id_q   <= '0;
      ctrl_q <= ALU_OP_NOP;
      op_a_q <= '0;
      op_b_q <= '0;
      rsp_q  <= '0;
    end else begin
      if (accept) begin
        ptr_q  <= arb_idx;
        id_q   <= arb_idx;
        ctrl_q <= sel_ctrl;
        if (illegal_sel) begin
          rsp_q <= '0;
        end else begin
          op_a_q <= sel_a;
          op_b_q <= sel_b;
        end
      end
      if (capture) begin
        rsp_q <= '{result: bus.alu_result, overflow: bus.alu_overflow, zero: bus.alu_zero};
      end
    end
  end

  // The accept pulse is suppressed while reset is held so no grant is shown
  // for a cycle whose latch will be discarded.
  assign bus.req_ready     = reset_n ? grant_now : '0;

  // Opcode only leaves NOP during EXEC; operands come straight from registers.
  assign bus.alu_control   = (state_q == ST_EXEC) ? ctrl_q : ALU_OP_NOP;
  assign bus.alu_first_op  = op_a_q;
  assign bus.alu_second_op = op_b_q;

  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_result    = rsp_q.result;
  assign bus.rsp_overflow  = rsp_q.overflow;
  assign bus.rsp_zero      = rsp_q.zero;

  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_request_scheduler.sv
// tb_alu_request_scheduler
//   Self-checking bench: behavioural ALU on the ALU port, a transaction-level
//   reference of the scheduler (round-robin pick, fixed response latency),
//   directed scenarios followed by randomized traffic.
module tb_alu_request_scheduler;
  import alu_request_scheduler_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } alu_out_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rsp_ready = 1'b0;
  always #5 clk = ~clk;

  alu_request_scheduler_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  alu_request_scheduler #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural ALU.
  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    o.ovf = 1'b0;
    case (op)
      4'b0000: o.res = a & b;
      4'b0001: o.res = a | b;
      4'b0010: o.res = a + b;
      4'b0011: o.res = a ^ b;
      4'b0100: o.res = ~(a | b);
      4'b0110: o.res = a - b;
      4'b0111: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: o.res = a << b[4:0];
      4'b1001: o.res = a >> b[4:0];
      4'b1010: o.res = $signed(a) >>> b[4:0];
      4'b1011: begin
        o.res = a + b;
        o.ovf = (a[31] == b[31]) && (o.res[31] != a[31]);
      end
      4'b1100: begin
        o.res = a - b;
        o.ovf = (a[31] != b[31]) && (o.res[31] != a[31]);
      end
      default: o.res = 32'hDEAD_BEEF;
    endcase
    o.zero = (o.res == 32'd0);
    return o;
  endfunction

  alu_out_t alu_now;
  assign alu_now          = alu_fn(bus.alu_control, bus.alu_first_op, bus.alu_second_op);
  assign bus.alu_result   = alu_now.res;
  assign bus.alu_overflow = alu_now.ovf;
  assign bus.alu_zero     = alu_now.zero;
  assign bus.rsp_ready    = rsp_ready;

  function automatic bit tb_illegal(input logic [3:0] op);
    return CHK_EN && (op inside {4'b0101, 4'b1101, 4'b1110, 4'b1111});
  endfunction

  // Requester state.
  bit          rq_v  [NUM_REQ];
  logic [3:0]  rq_op [NUM_REQ];
  logic [31:0] rq_a  [NUM_REQ];
  logic [31:0] rq_b  [NUM_REQ];

  logic [3:0]  legal_ops [12] = '{ALU_OP_AND, ALU_OP_OR, ALU_OP_ADD, ALU_OP_XOR, ALU_OP_NOR, ALU_OP_SUB,
                                  ALU_OP_SLT, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SADD, ALU_OP_SSUB};
  logic [3:0]  odd_ops   [4]  = '{4'b0101, 4'b1101, 4'b1110, 4'b1111};
  logic [31:0] corners   [5]  = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  // Reference model: one outstanding operation with a countdown to its response.
  bit          m_busy;
  int          m_left;
  int          m_ptr = NUM_REQ - 1;
  int          m_id;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  alu_out_t    m_out;
  bit          m_err;

  int                 acc_idx;
  logic [NUM_REQ-1:0] obs_ready;
  int                 cyc;
  int                 n_cmp;
  int                 n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    rq_v[i]  = 1'b1;
    rq_op[i] = op;
    rq_a[i]  = a;
    rq_b[i]  = b;
  endtask

  task automatic new_req(input int i);
    logic [3:0]  op;
    logic [31:0] a, b;
    op = ($urandom_range(7, 0) == 0) ? odd_ops[$urandom_range(3, 0)] : legal_ops[$urandom_range(11, 0)];
    case ($urandom_range(3, 0))
      0: begin a = $urandom; b = a; end
      1: begin a = $urandom_range(15, 0); b = $urandom_range(15, 0); end
      2: begin a = corners[$urandom_range(4, 0)]; b = corners[$urandom_range(4, 0)]; end
      default: begin a = $urandom; b = $urandom; end
    endcase
    set_req(i, op, a, b);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]           = rq_v[i];
      bus.req_control[4*i +: 4]  = rq_op[i];
      bus.req_op_a[32*i +: 32]   = rq_a[i];
      bus.req_op_b[32*i +: 32]   = rq_b[i];
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model over the edge.
  task automatic check_cycle();
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    bit ill;
    exp_ready = '0;
    g         = -1;
    acc_idx   = -1;
    if (!m_busy) begin
      if (reset_n) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (g < 0 && rq_v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", obs_ready, exp_ready);
      check("busy_idle", bus.busy, 0);
      check("rsp_valid_idle", bus.rsp_valid, 0);
      check("alu_ctrl_idle", bus.alu_control, ALU_OP_NOP);
    end else begin
      check("req_ready_busy", obs_ready, 0);
      check("busy", bus.busy, 1);
      check("rsp_valid", bus.rsp_valid, m_left == 0);
      if (m_left == 0) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_result", bus.rsp_result, m_out.res);
        check("rsp_overflow", bus.rsp_overflow, m_out.ovf);
        check("rsp_zero", bus.rsp_zero, m_out.zero);
        check("rsp_error", bus.rsp_error, m_err);
        check("alu_ctrl_resp", bus.alu_control, ALU_OP_NOP);
      end else begin
        check("alu_ctrl_op", bus.alu_control, (m_left == 1) ? m_op : ALU_OP_NOP);
        check("alu_first_op", bus.alu_first_op, m_a);
        check("alu_second_op", bus.alu_second_op, m_b);
      end
    end
    if (!reset_n) begin
      m_busy = 1'b0;
      m_ptr  = NUM_REQ - 1;
    end else if (!m_busy) begin
      if (g >= 0) begin
        ill     = tb_illegal(rq_op[g]);
        m_id    = g;
        m_op    = rq_op[g];
        m_a     = rq_a[g];
        m_b     = rq_b[g];
        m_out   = ill ? alu_out_t'(0) : alu_fn(rq_op[g], rq_a[g], rq_b[g]);
        m_err   = ill;
        m_left  = ill ? 0 : 2;
        m_ptr   = g;
        m_busy  = 1'b1;
        acc_idx = g;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, check 1 ns later, return at the next falling edge.
  task automatic step();
    drive();
    #1;
    obs_ready = bus.req_ready;
    check_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_overflow"}, bus.rsp_overflow, 0);
    check({tag, "_rsp_zero"}, bus.rsp_zero, 0);
    check({tag, "_rsp_error"}, bus.rsp_error, 0);
    check({tag, "_alu_control"}, bus.alu_control, ALU_OP_NOP);
    check({tag, "_alu_first_op"}, bus.alu_first_op, 0);
    check({tag, "_alu_second_op"}, bus.alu_second_op, 0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) rq_v[i] = 1'b0;
  endtask

  task automatic reset_dut();
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    clear_reqs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Issue one request on an idle scheduler and return when rsp_valid is up.
  task automatic do_single(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
    int t_acc;
    t_acc = -1;
    lat   = -1;
    clear_reqs();
    set_req(r, op, a, b);
    rsp_ready = 1'b0;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      step();
      if (t_acc < 0 && obs_ready[r]) begin
        t_acc    = k;
        rq_v[r]  = 1'b0;
        rq_op[r] = 4'($urandom);
        rq_a[r]  = $urandom;
        rq_b[r]  = $urandom;
      end
      if (t_acc >= 0 && bus.rsp_valid) lat = k + 1 - t_acc;
    end
    check("single_rsp_seen", lat >= 0, 1);
  endtask

  task automatic finish_rsp();
    clear_reqs();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int lat;
    int ng;
    int n_rsp;
    int g_id  [6];
    int g_cyc [6];

    for (int i = 0; i < NUM_REQ; i++) begin
      rq_v[i] = 1'b0; rq_op[i] = ALU_OP_NOP; rq_a[i] = '0; rq_b[i] = '0;
    end
    drive();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset_dut();

    // Single ADD from requester 0.
    do_single(0, ALU_OP_ADD, 32'd5, 32'd7, lat);
    check("t1_latency", lat, 3);
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_result", bus.rsp_result, 32'd12);
    check("t1_zero", bus.rsp_zero, 0);
    finish_rsp();

    // Signed-subtract overflow and a zero result.
    do_single(1, ALU_OP_SSUB, 32'h8000_0000, 32'd1, lat);
    check("t3_ssub_result", bus.rsp_result, 32'h7FFF_FFFF);
    check("t3_ssub_overflow", bus.rsp_overflow, 1);
    check("t3_ssub_id", bus.rsp_id, 1);
    finish_rsp();
    do_single(3, ALU_OP_SUB, 32'd9, 32'd9, lat);
    check("t3_sub_result", bus.rsp_result, 32'd0);
    check("t3_sub_zero", bus.rsp_zero, 1);
    finish_rsp();

    // Response stall: 10 cycles with rsp_ready low while others are requesting.
    do_single(2, ALU_OP_ADD, 32'd100, 32'd23, lat);
    check("t4_latency", lat, 3);
    set_req(0, ALU_OP_OR, 32'h0F, 32'hF0);
    set_req(3, ALU_OP_XOR, 32'h1, 32'h3);
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_hold_valid", bus.rsp_valid, 1);
      check("t4_hold_result", bus.rsp_result, 32'd123);
      check("t4_hold_id", bus.rsp_id, 2);
      check("t4_no_grant", obs_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_back_idle", bus.busy, 0);
    clear_reqs();
    rsp_ready = 1'b0;

    // Odd opcode 1101: early error response only when the check is built in.
    do_single(0, 4'b1101, 32'd3, 32'd4, lat);
    check("t6_latency", lat, CHK_EN ? 1 : 3);
    check("t6_error", bus.rsp_error, CHK_EN);
    check("t6_result", bus.rsp_result, CHK_EN ? 32'd0 : 32'hDEAD_BEEF);
    finish_rsp();

    // All four requesting continuously, consumer always ready.
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_OP_ADD, $urandom, $urandom);
    for (int j = 0; j < 6; j++) begin g_id[j] = -1; g_cyc[j] = -100; end
    rsp_ready = 1'b1;
    ng = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (obs_ready != '0) begin
        if (ng < 6) begin
          g_id[ng]  = onehot_idx(obs_ready);
          g_cyc[ng] = k;
        end
        ng++;
        if (onehot_idx(obs_ready) >= 0) set_req(onehot_idx(obs_ready), ALU_OP_ADD, $urandom, $urandom);
      end
    end
    check("t2_grant_count", ng >= 5, 1);
    for (int j = 0; j < 5; j++) begin
      check("t2_grant_order", g_id[j], j % 4);
      if (j > 0) check("t2_grant_gap", g_cyc[j] - g_cyc[j-1], 4);
    end
    clear_reqs();
    finish_rsp();
    finish_rsp();
    finish_rsp();
    finish_rsp();

    // Reset while an operation is in EXEC.
    set_req(1, ALU_OP_ADD, 32'd40, 32'd2);
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (m_busy && m_left == 1) break;
      step();
      if (acc_idx == 1) rq_v[1] = 1'b0;
    end
    check("t5_reached_exec", m_busy && m_left == 1, 1);
    reset_n = 1'b0;
    set_req(2, ALU_OP_AND, 32'hFF, 32'h0F);
    step();
    check_reset_outputs("t5");
    step();
    reset_n = 1'b1;
    clear_reqs();
    n_rsp = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.rsp_valid) n_rsp++;
    end
    check("t5_no_response", n_rsp, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_idx == i) begin
          if ($urandom_range(1, 0) == 1) begin
            new_req(i);
          end else begin
            rq_v[i]  = 1'b0;
            rq_op[i] = 4'($urandom);
            rq_a[i]  = $urandom;
            rq_b[i]  = $urandom;
          end
        end else if (!rq_v[i]) begin
          if ($urandom_range(2, 0) == 0) new_req(i);
        end else if ($urandom_range(15, 0) == 0) begin
          rq_v[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
